bullet_controller: RTL
======================

Name: bullet_controller

Overview:
Owns the player's bullet pool. It spawns bullets on fire requests, moves them upward at a fixed rate, and retires them when they leave the top of the screen or when the hit vector reports a collision. Its position/active outputs feed the collision inputs of the enemy controller and the renderer. It consumes that block's one-cycle bullet_hit pulses.

Parameters:
BULLET_COUNT, 8, number of bullet slots (fixed 8 by top-level wiring)
STEP_DIV, 20'd262144, clk25 cycles per movement step
STEP_PX, 4, pixels moved upward per step
SPAWN_X_OFF, 15, x offset added to player_x at spawn (centre of 32-px sprite)
COOLDOWN, 22'd2500000, minimum cycles between spawns (100 ms)
HIT_GUARD, 2, cycles after spawn during which bullet_hit for that slot is ignored

Ports:
clk25  in  1  25 MHz pixel/game clock
reset_n  in  1  asynchronous active-low reset
fire  in  1  fire button level, already synchronised to clk25
player_x  in  10  player sprite left x
player_y  in  10  player sprite top y
bullet_hit  in  BULLET_COUNT  per-slot one-cycle hit pulse from the collision logic
bullet_x  out  10*BULLET_COUNT  slot k at bits [10k+9:10k]
bullet_y  out  10*BULLET_COUNT  slot k at bits [10k+9:10k]
bullet_active  out  BULLET_COUNT  slot k is live
shot_fired  out  1  one-cycle pulse on each spawn
pool_full  out  1  all slots active
active_count  out  4  number of active slots

Behaviour:
- Reset (async, reset_n=0): all bullet_x/bullet_y=0, bullet_active=0, shot_fired=0, pool_full=0, active_count=0, step timer=0, cooldown=0, fire_d=0, guard counters=0. Release is taken synchronously on the next clk25 edge.
- Fire edge: fire_rise = fire & ~fire_d, with fire_d registered each cycle. A held button fires only once.
- Spawn occurs when fire_rise && cooldown==0 && at least one slot was inactive at the start of the cycle.
  - Target slot: the lowest-index inactive slot.
  - Next cycle: x = player_x + SPAWN_X_OFF (10-bit, wraps), y = player_y, active=1, guard=HIT_GUARD, cooldown=COOLDOWN-1, shot_fired=1 for exactly one cycle.
  - A rejected fire_rise (cooldown or full pool) is dropped, not queued.
- Cooldown: decrements by 1 per cycle while nonzero and saturates at 0.
- Step timer: counts 0..STEP_DIV-1 and wraps; step=1 in the cycle the timer equals STEP_DIV-1.
  - On step, each active slot with y >= STEP_PX gets y -= STEP_PX.
  - An active slot with y < STEP_PX is deactivated (top exit) and its x/y hold.
- Hit: if bullet_hit[k]=1, bullet_active[k]=1 and guard[k]==0, slot k is deactivated next cycle. Hits on inactive or guarded slots are ignored. Guard decrements each cycle to 0.
- Same-cycle priority per slot: hit > top-exit > move. Spawn never targets a slot that is active this cycle, so a slot freed this cycle is spawnable one cycle later at the earliest.
- Spawn and step in the same cycle: the spawned bullet is not moved in that cycle.
- Status outputs: active_count and pool_full are registered and reflect bullet_active of the same cycle (popcount and AND over slots).
- Latency:
  - fire rising edge to bullet_active: 1 cycle after the edge is sampled.
  - bullet_hit to bullet_active low: 1 cycle.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package game_pkg: COORD_W=10, SCREEN_W=640, SCREEN_H=480, SPRITE_SZ=32, BULLET_COUNT=8, ENEMY_COUNT=4.
- Sub-module slot_alloc: combinational lowest-free priority encoder. Input is the active vector; outputs are a one-hot grant and an any_free flag. It is reusable for the enemy respawn pool.

Test Plan (bench uses STEP_DIV=4, STEP_PX=4, COOLDOWN=10, HIT_GUARD=2):
1. Reset mid-flight: 3 bullets live, then reset_n=0 asynchronously between edges -> all outputs 0 immediately; after release, fire works on the first edge.
2. Spawn/move: player_x=100, player_y=400, fire 0->1 -> next cycle slot0 at x=115, y=400, active, shot_fired=1 for one cycle; after 8 cycles y=392; holding fire produces no second shot.
3. Cooldown and full pool: fire pulses 5 cycles apart -> second pulse ignored. Pulses 11 cycles apart fill slots 0..7 -> pool_full=1, active_count=8, and a 9th pulse gives no shot_fired.
4. Top exit: spawn with player_y=6 -> y=2 after the first step, inactive after the second; an immediate refire reuses slot0.
5. Hit handling:
   - bullet_hit=8'b0000_0100 on live slot2 -> slot2 inactive next cycle, others unaffected.
   - hit on slot0 one cycle after spawn -> ignored (guard).
   - hit on inactive slot5 -> no change.
6. Simultaneous events: step, hit on slot1 and top exit on slot3 in the same cycle as a fire spawn -> slots 1 and 3 cleared, new bullet in the lowest previously free slot at its unmoved spawn y, active_count correct the following cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants and helpers for the sprite controllers.
// Latency: none; constants and pure combinational functions only.
// Backpressure: none.
// Contents: screen/sprite geometry, pool sizes, and a popcount helper for pool status.
package game_pkg;

  localparam int COORD_W      = 10;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int SPRITE_SZ    = 32;
  localparam int BULLET_COUNT = 8;
  localparam int ENEMY_COUNT  = 4;

  // Wide enough to hold BULLET_COUNT itself (8 needs 4 bits).
  localparam int BULLET_CNT_W = $clog2(BULLET_COUNT + 1);

  function automatic logic [BULLET_CNT_W-1:0] count_ones(input logic [BULLET_COUNT-1:0] v);
    logic [BULLET_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < BULLET_COUNT; i++) begin
      c = c + BULLET_CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/bullet_controller_slot_alloc.sv
// Lowest-index free slot picker for a pool of N slots.
// Latency: purely combinational, zero cycles.
// Backpressure: none; any_free_o low means grant_o is all zero.
// Ports: active_i (slot busy vector), grant_o (one-hot lowest free slot), any_free_o.
module slot_alloc #(
  parameter int N = 8
) (
  input  logic [N-1:0] active_i,
  output logic [N-1:0] grant_o,
  output logic         any_free_o
);

  logic [N-1:0] free;

  assign free       = ~active_i;
  // x & -x keeps only the lowest set bit of the free mask.
  assign grant_o    = free & (~free + N'(1));
  assign any_free_o = |free;

endmodule

// File: rtl/bullet_controller.sv
// Player bullet pool: spawns on fire edges, moves bullets upward, retires on top exit or hit.
// Latency: fire edge -> bullet live 1 cycle; bullet_hit -> bullet inactive 1 cycle.
// Backpressure: none; fire edges during cooldown or with a full pool are dropped.
// Ports: clk25/reset_n, fire level, player_x/player_y, bullet_hit pulses in;
//        packed bullet_x/bullet_y, bullet_active, shot_fired, pool_full, active_count out.
module bullet_controller
  import game_pkg::*;
#(
  parameter logic [19:0] STEP_DIV    = 20'd262144,
  parameter int          STEP_PX     = 4,
  parameter int          SPAWN_X_OFF = 15,
  parameter logic [21:0] COOLDOWN    = 22'd2500000,
  parameter int          HIT_GUARD   = 2
) (
  input  logic                              clk25,
  input  logic                              reset_n,
  input  logic                              fire,
  input  logic [COORD_W-1:0]                player_x,
  input  logic [COORD_W-1:0]                player_y,
  input  logic [BULLET_COUNT-1:0]           bullet_hit,
  output logic [COORD_W*BULLET_COUNT-1:0]   bullet_x,
  output logic [COORD_W*BULLET_COUNT-1:0]   bullet_y,
  output logic [BULLET_COUNT-1:0]           bullet_active,
  output logic                              shot_fired,
  output logic                              pool_full,
  output logic [BULLET_CNT_W-1:0]           active_count
);

  localparam int GUARD_W = (HIT_GUARD > 1) ? $clog2(HIT_GUARD + 1) : 1;

  localparam logic [COORD_W-1:0] STEP_PX_C    = COORD_W'(STEP_PX);
  localparam logic [COORD_W-1:0] SPAWN_OFF_C  = COORD_W'(SPAWN_X_OFF);
  localparam logic [GUARD_W-1:0] GUARD_INIT_C = GUARD_W'(HIT_GUARD);

  logic [COORD_W-1:0]      x_q     [BULLET_COUNT];
  logic [COORD_W-1:0]      x_d     [BULLET_COUNT];
  logic [COORD_W-1:0]      y_q     [BULLET_COUNT];
  logic [COORD_W-1:0]      y_d     [BULLET_COUNT];
  logic [GUARD_W-1:0]      guard_q [BULLET_COUNT];
  logic [GUARD_W-1:0]      guard_d [BULLET_COUNT];
  logic [BULLET_COUNT-1:0] act_q, act_d;
  logic [21:0]             cd_q, cd_d;
  logic [19:0]             timer_q, timer_d;
  logic                    fire_d_q;
  logic                    shot_q;
  logic                    full_q;
  logic [BULLET_CNT_W-1:0] cnt_q;

  logic [BULLET_COUNT-1:0] grant;
  logic                    any_free;
  logic                    fire_rise;
  logic                    step;
  logic                    spawn;

  // Allocation looks at the start-of-cycle active vector, so a slot retired
  // this cycle is not reused until the next one.
  slot_alloc #(.N(BULLET_COUNT)) u_alloc (
    .active_i   (act_q),
    .grant_o    (grant),
    .any_free_o (any_free)
  );

  assign fire_rise = fire & ~fire_d_q;
  assign step      = (timer_q == STEP_DIV - 20'd1);
  assign spawn     = fire_rise & (cd_q == '0) & any_free;

  assign timer_d = step ? '0 : timer_q + 20'd1;
  assign cd_d    = spawn ? COOLDOWN - 22'd1 : ((cd_q != '0) ? cd_q - 22'd1 : cd_q);

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    guard_d = guard_q;
    act_d   = act_q;
    for (int k = 0; k < BULLET_COUNT; k++) begin
      if (guard_q[k] != '0) begin
        guard_d[k] = guard_q[k] - GUARD_W'(1);
      end
      // Per-slot priority: accepted hit, then top exit, then move.
      if (act_q[k]) begin
        if (bullet_hit[k] && (guard_q[k] == '0)) begin
          act_d[k] = 1'b0;
        end else if (step) begin
          if (y_q[k] < STEP_PX_C) begin
            act_d[k] = 1'b0;
          end else begin
            y_d[k] = y_q[k] - STEP_PX_C;
          end
        end
      end
      // Granted slot was inactive at cycle start, so nothing above touched it;
      // a spawn coinciding with a step lands at the unmoved player_y.
      if (spawn && grant[k]) begin
        x_d[k]     = player_x + SPAWN_OFF_C;
        y_d[k]     = player_y;
        act_d[k]   = 1'b1;
        guard_d[k] = GUARD_INIT_C;
      end
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < BULLET_COUNT; k++) begin
        x_q[k]     <= '0;
        y_q[k]     <= '0;
        guard_q[k] <= '0;
      end
      act_q    <= '0;
      cd_q     <= '0;
      timer_q  <= '0;
      fire_d_q <= 1'b0;
      shot_q   <= 1'b0;
      full_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      for (int k = 0; k < BULLET_COUNT; k++) begin
        x_q[k]     <= x_d[k];
        y_q[k]     <= y_d[k];
        guard_q[k] <= guard_d[k];
      end
      act_q    <= act_d;
      cd_q     <= cd_d;
      timer_q  <= timer_d;
      fire_d_q <= fire;
      shot_q   <= spawn;
      // Status derives from act_d so it lines up with bullet_active.
      full_q   <= &act_d;
      cnt_q    <= count_ones(act_d);
    end
  end

  for (genvar g = 0; g < BULLET_COUNT; g++) begin : g_pack
    assign bullet_x[COORD_W*g +: COORD_W] = x_q[g];
    assign bullet_y[COORD_W*g +: COORD_W] = y_q[g];
  end

  assign bullet_active = act_q;
  assign shot_fired    = shot_q;
  assign pool_full     = full_q;
  assign active_count  = cnt_q;

endmodule
